// File: rtl/uart_mmio_responder.sv
// UART MMIO responder: CPU load/store front end for the TX and RX serial cores.
// Owns the TX launch handshake and the RX holding register with overrun flag.
module uart_mmio_responder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            Device_sel_i,
  input  logic                  Mem_Write_i,
  input  logic                  Mem_Read_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  output logic [DATA_WIDTH-1:0] Read_Data_o,
  output logic [7:0]            Tx_Data_o,
  output logic                  Tx_Start_o,
  input  logic                  Tx_Busy_i,
  input  logic [7:0]            Rx_Data_i,
  input  logic                  Rx_Valid_i
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

  tx_state_t  tx_state;
  tx_state_t  tx_next;
  logic [7:0] tx_data_r;
  logic [7:0] tx_shadow;
  logic [7:0] rx_data_r;
  logic       rx_full;
  logic       rx_overrun;

  logic tx_idle;
  logic wr_tx;
  logic wr_ctl;
  logic send;
  logic pop;
  logic ovr_set;
  logic ovr_clr;

  // Only the low byte of a store carries data.
  logic unused_wdata;
  assign unused_wdata = ^Write_Data_i;

  assign tx_idle = (tx_state == IDLE);
  assign wr_tx   = Mem_Write_i && (Device_sel_i == 2'b01);
  assign wr_ctl  = Mem_Write_i && (Device_sel_i == 2'b11);
  assign send    = wr_ctl && Write_Data_i[0] && tx_idle;
  assign pop     = Mem_Read_i && (Device_sel_i == 2'b10);
  assign ovr_set = Rx_Valid_i && rx_full && !pop;
  assign ovr_clr = wr_ctl && Write_Data_i[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state  <= IDLE;
      tx_data_r <= 8'h00;
      tx_shadow <= 8'h00;
    end else begin
      tx_state <= tx_next;
      if (wr_tx && tx_idle) tx_data_r <= Write_Data_i[7:0];
      if (send) tx_shadow <= tx_data_r;
    end
  end

  always_comb begin
    tx_next    = tx_state;
    Tx_Start_o = 1'b0;
    unique case (tx_state)
      IDLE:      if (send) tx_next = LAUNCH;
      LAUNCH: begin
        Tx_Start_o = 1'b1;
        tx_next    = WAIT_BUSY;
      end
      WAIT_BUSY: if (Tx_Busy_i) tx_next = WAIT_DONE;
      WAIT_DONE: if (!Tx_Busy_i) tx_next = IDLE;
    endcase
  end

  assign Tx_Data_o = tx_shadow;

  // A capture in the same cycle as a pop refills the register cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_r  <= 8'h00;
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (Rx_Valid_i) begin
        rx_data_r <= Rx_Data_i;
        rx_full   <= 1'b1;
      end else if (pop) begin
        rx_full <= 1'b0;
      end
      if (ovr_set) rx_overrun <= 1'b1;
      else if (ovr_clr) rx_overrun <= 1'b0;
    end
  end

  always_comb begin
    Read_Data_o = '0;
    case (Device_sel_i)
      2'b01:   Read_Data_o[7:0] = tx_data_r;
      2'b10:   Read_Data_o[7:0] = rx_data_r;
      2'b11:   Read_Data_o[2:0] = {rx_overrun, rx_full, !tx_idle};
      default: Read_Data_o = '0;
    endcase
  end

endmodule

// File: doc/uart_mmio_responder.md
# uart_mmio_responder

Memory-mapped UART register responder sitting between the CPU data-memory port and the UART TX/RX serial cores in the multicycle RISC-V. It consumes the 2-bit device select produced by the address decoder (TX data, RX data, TX control/status) and answers CPU loads and stores. It owns the TX launch handshake and the RX holding register with overrun detection. All state is in the `clk` domain.

## Interface
- `DATA_WIDTH`, default 32: CPU data bus width; must be ≥ 8.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `Device_sel_i` in 2: device select from the decoder.
  - 2'b01: TX data register, address 0x1001002c.
  - 2'b10: RX data register, address 0x10010030.
  - 2'b11: TX control/status register, address 0x10010028.
  - 2'b00: not this block.
- `Mem_Write_i` in 1: one-cycle store strobe.
- `Mem_Read_i` in 1: one-cycle load strobe, one pulse per load instruction.
- `Write_Data_i` in DATA_WIDTH: store data.
- `Read_Data_o` out DATA_WIDTH: load data, combinational from `Device_sel_i`.
- `Tx_Data_o` out 8: byte presented to the TX core.
- `Tx_Start_o` out 1: one-cycle launch pulse to the TX core.
- `Tx_Busy_i` in 1: TX core busy, high while shifting.
- `Rx_Data_i` in 8: received byte from the RX core.
- `Rx_Valid_i` in 1: one-cycle pulse, `Rx_Data_i` valid.

## Operation
- TX data register `tx_data_r[7:0]`.
  - Store with sel 01 and `Mem_Write_i` loads `Write_Data_i[7:0]` when `tx_state == IDLE`; otherwise the store is ignored.
  - Load with sel 01 returns {0, `tx_data_r`}.
- Control/status, sel 11.
  - Store: bit0=1 requests a send if IDLE, ignored otherwise. Bit1=1 clears `rx_overrun`. Other bits are ignored.
  - Load returns {0…, `rx_overrun`, `rx_full`, `tx_busy`} in bits [2:0]; all upper bits are 0.
  - `tx_busy` = (`tx_state` != IDLE).
- TX FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE → LAUNCH on a send request. `tx_shadow` ← `tx_data_r` on that edge.
  - LAUNCH: `Tx_Start_o` = 1 for exactly this one cycle, then → WAIT_BUSY.
  - WAIT_BUSY: → WAIT_DONE when `Tx_Busy_i` = 1.
  - WAIT_DONE: → IDLE when `Tx_Busy_i` = 0.
  - `Tx_Data_o` = `tx_shadow` at all times. It is stable from LAUNCH until IDLE.
- RX path.
  - `Rx_Valid_i` captures `Rx_Data_i` into `rx_data_r` and sets `rx_full`.
  - If `rx_full` is already 1 and there is no pop in the same cycle: overwrite, and set sticky `rx_overrun`.
  - Load with sel 10 returns {0, `rx_data_r`}. A load with `Mem_Read_i` = 1 pops: `rx_full` ← 0.
  - Reading RX while `rx_full` = 0 returns the stale `rx_data_r` and has no side effects.
- sel 00: `Read_Data_o` = 0. Stores and loads have no effect.
- Width: only bits [7:0] of a store are data; upper `Write_Data_i` bits are ignored.

## Timing
- Reset (synchronous, dominates all other inputs):
  - `tx_state` = IDLE.
  - `tx_data_r`, `tx_shadow`, `rx_data_r` = 0.
  - `rx_full`, `rx_overrun` = 0.
  - Outputs: `Tx_Start_o` = 0, `Tx_Data_o` = 0, `Read_Data_o` = 0 (with sel 00).
- Store-to-launch latency: send store at edge N → `Tx_Start_o` high during cycle N+1 → `tx_busy` reads 1 from cycle N+1.
- Register write latency: a store updates registers on the same edge. Load data is combinational in the same cycle.
- Simultaneous `Rx_Valid_i` and RX pop in one cycle:
  - The load returns the old byte.
  - The new byte is captured; `rx_full` stays 1; `rx_overrun` is unchanged.
- Simultaneous `Rx_Valid_i` with an overrun-clear store while full: the set wins, so `rx_overrun` = 1.
- Send request in the same cycle as a TX data store (impossible on a single port): not supported.
- `Tx_Busy_i` never rising leaves the FSM in WAIT_BUSY. The only recovery is `reset`.
- Reset mid-transmission: FSM → IDLE and `Tx_Start_o` = 0. The TX core is not aborted by this block.

## Test plan
- **Reset:** assert `reset` 2 cycles with random inputs → all registers 0, `Tx_Start_o` = 0, status load = 0x0.
- **TX launch:**
  - Stimulus: store 0x41 to sel 01, store 0x1 to sel 11; `Tx_Busy_i` rises 2 cycles after the pulse and stays high 10 cycles.
  - Required response: exactly one `Tx_Start_o` pulse with `Tx_Data_o` = 0x41; status bit0 = 1 until 1 cycle after `Tx_Busy_i` falls.
- **Busy lockout:** during that transmission, store 0x55 to sel 01 and 0x1 to sel 11 → `tx_data_r` stays 0x41, no second pulse.
- **RX single:** `Rx_Valid_i` with 0xA5 → status = 0x2, RX load returns 0x000000A5, status after pop = 0x0.
- **RX overrun:**
  - Stimulus: bytes 0x11 then 0x22 without a pop.
  - Required response: status = 0x6 and RX load = 0x22; store 0x2 to sel 11 → status = 0x2.
- **Simultaneous:**
  - Stimulus: with 0x11 held, pulse `Rx_Valid_i` = 0x33 in the same cycle as the RX pop.
  - Required response: load returns 0x11, status = 0x2 after, next load returns 0x33.
